cla_accum_frame_38bit: RTL and testbench

- Sequential accumulation stage that sits directly upstream of the 38-bit carry-lookahead adder and consumes its result.
- Each cycle it feeds the adder the running accumulator and the incoming operand, then registers the 39-bit result back.
- It sums a frame of N 38-bit operands received over a valid/ready stream.
- It presents the final modulo-2^38 sum, a sticky carry-overflow flag and the beat count on an output valid/ready handshake.

---
 rtl/cla_accum_frame_38bit_if.sv | 29 ++
 rtl/cla_accum_frame_38bit.sv | 141 ++++++++++++++
 tb/tb_cla_accum_frame_38bit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/cla_accum_frame_38bit_if.sv
// rtl/cla_accum_frame_38bit_if.sv - operand stream, frame control and result handshake bundle
interface cla_accum_frame_38bit_if #(
  parameter int WIDTH = 38,
  parameter int CNT_W = 8
);
  logic             i_start;
  logic [CNT_W-1:0] i_len;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_data;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_sum;
  logic             o_ovf;
  logic [CNT_W-1:0] o_count;
  logic             o_busy;

  // Stimulus side: drives the frame control, operands and result acceptance
  modport master (
    output i_start, i_len, i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_sum, o_ovf, o_count, o_busy
  );

  // Accumulator side
  modport slave (
    input  i_start, i_len, i_valid, i_data, i_ready,
    output o_ready, o_valid, o_sum, o_ovf, o_count, o_busy
  );
endinterface

// File: rtl/cla_accum_frame_38bit.sv
// rtl/cla_accum_frame_38bit.sv - frame accumulator around a carry-lookahead adder
module cla_adder #(
  parameter int WIDTH = 38
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH:0]   w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Carries are looked ahead inside 4-bit groups from the group carry-in;
  // group carry-ins chain from one group to the next.
  always_comb begin
    w_c[0] = i_cin;
    for (int i = 0; i < WIDTH; i++) begin
      int   base;
      logic t;
      logic pr;
      base = (i / 4) * 4;
      t    = w_g[i];
      pr   = w_p[i];
      for (int m = i - 1; m >= base; m--) begin
        t  = t | (pr & w_g[m]);
        pr = pr & w_p[m];
      end
      w_c[i+1] = t | (pr & w_c[base]);
    end
  end

  assign o_sum  = w_p ^ w_c[WIDTH-1:0];
  assign o_cout = w_c[WIDTH];
endmodule

module cla_accum_frame_38bit #(
  parameter int WIDTH = 38,
  parameter int CNT_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  cla_accum_frame_38bit_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [CNT_W-1:0] w_len_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_ovf_nxt;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  cla_adder #(.WIDTH(WIDTH)) u_add (
    .i_a    (r_acc),
    .i_b    (bus.i_data),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // State and datapath registers; reset discards any partial frame
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_len   <= w_len_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // Frame sequencing: start, accept len beats through the adder, hold result until taken
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_len_nxt   = r_len;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_acc_nxt = '0;
          w_cnt_nxt = '0;
          w_ovf_nxt = 1'b0;
          if (bus.i_len != '0) begin
            w_len_nxt   = bus.i_len;
            w_state_nxt = S_ACCUM;
          end else begin
            // Empty frame goes straight to the result phase with a zero sum
            w_state_nxt = S_DONE;
          end
        end
      end
      S_ACCUM: begin
        if (bus.i_valid) begin
          w_acc_nxt = w_sum;
          w_ovf_nxt = r_ovf | w_cout;
          w_cnt_nxt = r_cnt + ONE;
          if (r_cnt == (r_len - ONE)) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (bus.i_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.o_ready = (r_state == S_ACCUM);
  assign bus.o_valid = (r_state == S_DONE);
  assign bus.o_busy  = (r_state != S_IDLE);
  assign bus.o_sum   = r_acc;
  assign bus.o_ovf   = r_ovf;
  assign bus.o_count = r_cnt;
endmodule

// File: tb/tb_cla_accum_frame_38bit.sv
// tb/tb_cla_accum_frame_38bit.sv - directed scoreboard bench for the frame accumulator
module tb_cla_accum_frame_38bit;
  localparam int WIDTH = 38;
  localparam int CNT_W = 8;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             ovf;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic i_clk;
  logic i_rst_n;
  int   n_cmp;
  int   n_fail;
  exp_t sb[$];

  logic [WIDTH-1:0] m_acc;
  logic             m_ovf;
  logic [CNT_W-1:0] m_cnt;

  cla_accum_frame_38bit_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus_if ();

  cla_accum_frame_38bit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus_if)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic start_frame(input logic [CNT_W-1:0] len);
    bus_if.i_start = 1'b1;
    bus_if.i_len   = len;
    m_acc = '0;
    m_ovf = 1'b0;
    m_cnt = '0;
    tick();
    bus_if.i_start = 1'b0;
    bus_if.i_len   = $urandom_range(255, 0);
  endtask

  task automatic send_beat(input logic [WIDTH-1:0] d, input int gap);
    logic [WIDTH:0] r;
    int k;
    bus_if.i_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      bus_if.i_data = WIDTH'($urandom);
      tick();
      check("gap_count_hold", 64'(bus_if.o_count), 64'(m_cnt));
    end
    bus_if.i_data  = d;
    bus_if.i_valid = 1'b1;
    k = 0;
    while (!bus_if.o_ready && k < 20) begin
      tick();
      k++;
    end
    check("beat_ready", 64'(bus_if.o_ready), 64'd1);
    tick();
    bus_if.i_valid = 1'b0;
    bus_if.i_data  = WIDTH'($urandom);
    r = {1'b0, m_acc} + {1'b0, d};
    m_acc = r[WIDTH-1:0];
    m_ovf = m_ovf | r[WIDTH];
    m_cnt = m_cnt + 1'b1;
  endtask

  task automatic push_expect();
    exp_t e;
    e.sum = m_acc;
    e.ovf = m_ovf;
    e.cnt = m_cnt;
    sb.push_back(e);
  endtask

  task automatic wait_result(input string tag);
    exp_t e;
    int k;
    k = 0;
    while (!bus_if.o_valid && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_valid"}, 64'(bus_if.o_valid), 64'd1);
    check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_sum"},   64'(bus_if.o_sum),   64'(e.sum));
      check({tag, "_ovf"},   64'(bus_if.o_ovf),   64'(e.ovf));
      check({tag, "_count"}, 64'(bus_if.o_count), 64'(e.cnt));
      check({tag, "_busy"},  64'(bus_if.o_busy),  64'd1);
      check({tag, "_ready"}, 64'(bus_if.o_ready), 64'd0);
    end
  endtask

  task automatic handshake(input string tag);
    bus_if.i_ready = 1'b1;
    tick();
    bus_if.i_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(bus_if.o_valid), 64'd0);
    check({tag, "_busy_drop"},  64'(bus_if.o_busy),  64'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] held_sum;
    n_cmp  = 0;
    n_fail = 0;
    bus_if.i_start = 1'b0;
    bus_if.i_len   = '0;
    bus_if.i_valid = 1'b0;
    bus_if.i_data  = '0;
    bus_if.i_ready = 1'b0;
    i_rst_n = 1'b1;

    // Asynchronous reset applied mid-cycle
    #2 i_rst_n = 1'b0;
    #1;
    check("rst_ready", 64'(bus_if.o_ready), 64'd0);
    check("rst_valid", 64'(bus_if.o_valid), 64'd0);
    check("rst_sum",   64'(bus_if.o_sum),   64'd0);
    check("rst_ovf",   64'(bus_if.o_ovf),   64'd0);
    check("rst_count", 64'(bus_if.o_count), 64'd0);
    check("rst_busy",  64'(bus_if.o_busy),  64'd0);
    tick();
    i_rst_n = 1'b1;
    tick();
    check("idle_busy", 64'(bus_if.o_busy), 64'd0);

    // Basic frame 5 + 7 + 11
    start_frame(8'd3);
    check("basic_busy_accum",  64'(bus_if.o_busy),  64'd1);
    check("basic_ready_accum", 64'(bus_if.o_ready), 64'd1);
    send_beat(38'd5, 0);
    send_beat(38'd7, 0);
    send_beat(38'd11, 0);
    push_expect();
    check("basic_latency", 64'(bus_if.o_valid), 64'd1);
    check("basic_sum_const", 64'(bus_if.o_sum), 64'd23);
    wait_result("basic");
    handshake("basic");

    // Wrap-around sets the sticky overflow flag
    start_frame(8'd2);
    send_beat(38'h3F_FFFF_FFFF, 0);
    send_beat(38'h2, 0);
    push_expect();
    check("wrap_sum_const", 64'(bus_if.o_sum), 64'h1);
    check("wrap_ovf_const", 64'(bus_if.o_ovf), 64'd1);
    wait_result("wrap");
    handshake("wrap");

    // Overflow flag cleared by the next start
    start_frame(8'd1);
    check("clr_ovf_at_start", 64'(bus_if.o_ovf), 64'd0);
    send_beat(38'd4, 0);
    push_expect();
    wait_result("after_wrap");
    handshake("after_wrap");

    // Input stalls, then result backpressure with a stray start in DONE
    start_frame(8'd4);
    send_beat(38'd1, 0);
    send_beat(38'd2, 0);
    send_beat(38'd3, 2);
    send_beat(38'd4, 1);
    push_expect();
    check("stall_sum_const", 64'(bus_if.o_sum), 64'd10);
    wait_result("stall");
    held_sum = bus_if.o_sum;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        bus_if.i_start = 1'b1;
        bus_if.i_len   = 8'd7;
      end
      tick();
      bus_if.i_start = 1'b0;
      check("bp_valid_hold", 64'(bus_if.o_valid), 64'd1);
      check("bp_sum_hold",   64'(bus_if.o_sum),   64'(held_sum));
      check("bp_count_hold", 64'(bus_if.o_count), 64'd4);
    end
    handshake("stall");

    // Empty frame
    start_frame(8'd0);
    push_expect();
    check("empty_ready", 64'(bus_if.o_ready), 64'd0);
    check("empty_latency", 64'(bus_if.o_valid), 64'd1);
    wait_result("empty");
    handshake("empty");

    // Reset in the middle of a frame discards it
    start_frame(8'd5);
    send_beat(38'd1, 0);
    send_beat(38'd1, 0);
    check("midrst_pre_count", 64'(bus_if.o_count), 64'd2);
    #2 i_rst_n = 1'b0;
    #1;
    check("midrst_busy",  64'(bus_if.o_busy),  64'd0);
    check("midrst_count", 64'(bus_if.o_count), 64'd0);
    check("midrst_sum",   64'(bus_if.o_sum),   64'd0);
    tick();
    i_rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("midrst_no_valid", 64'(bus_if.o_valid), 64'd0);
    end
    start_frame(8'd1);
    send_beat(38'd9, 0);
    push_expect();
    wait_result("post_rst");
    handshake("post_rst");

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
